dmem_access_unit: RTL

MEM-stage data-memory initiator for the rv32i pipeline. Takes the load/store in MEM, drives the data-cache request until `data_resp`, and stalls the pipeline meanwhile. It builds byte enables and lane-shifted store data, and sign/zero-extends load data for MEM/WB. It is the requesting end of the `data_read`/`data_write`/`data_resp` handshake whose response side MEM/WB consumes.

---
 rtl/rv32i_types.sv | 58 +++++
 rtl/dmem_access_unit_load_extend.sv | 29 ++
 rtl/dmem_access_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i types: control word, funct3 encodings, data-memory FSM states and lane helpers.
// Pure declarations, no logic of its own.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } rv32i_control_word;

    // funct3[1:0] encodes access size: 0 byte, 1 half, 2 word.
    // Misaligned offsets truncate down to the natural boundary of the access.
    function automatic logic [1:0] access_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return off;
            2'b01:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Load lane select and sign/zero extension; shared with the forwarding path.
// Combinational, no handshake.
module load_extend
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        result   = 32'h0;
        case (load_funct3_t'(funct3))
            lb:      result = {{24{byte_sel[7]}}, byte_sel};
            lbu:     result = {24'h0, byte_sel};
            lh:      result = {{16{half_sel[15]}}, half_sel};
            lhu:     result = {16'h0, half_sel};
            lw:      result = rdata;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-cache initiator; optional MISALIGN_TRAP_EN skips the request for misaligned half/word ops.
// Request visible one cycle after the op arrives, result one cycle after data_resp; stalls the pipe until then.
module dmem_access_unit
    import rv32i_types::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  rv32i_control_word    mem_ctrl,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_rs2,
    input  logic                 flush,
    output logic                 data_read,
    output logic                 data_write,
    output logic [31:0]          data_addr,
    output logic [3:0]           data_mbe,
    output logic [31:0]          data_wdata,
    input  logic [31:0]          data_rdata,
    input  logic                 data_resp,
    output logic                 stall,
    output logic [31:0]          load_data,
    output logic [3:0]           mem_byte_en_o,
    output logic                 misalign,
    output logic [TIMEOUT_W-1:0] wait_cycles
);

    dmem_state_t state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [3:0]  lane_q;
    logic        is_load_q;
    logic        flushed_q;
    logic        misalign_q;

    logic        start;
    logic        trap;
    logic [1:0]  offset_eff;
    logic [3:0]  lane;
    logic [31:0] ext_data;

    assign start      = (state == IDLE) && mem_valid && (mem_ctrl.mem_read || mem_ctrl.mem_write) && !flush;
    assign offset_eff = access_offset(mem_ctrl.funct3[1:0], mem_addr[1:0]);
    assign lane       = lane_mask(mem_ctrl.funct3[1:0], mem_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign trap = misaligned(mem_ctrl.funct3[1:0], mem_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // The accepting IDLE cycle must already freeze the pipe, so stall cannot be registered.
    assign stall    = start || (state == REQ);
    assign misalign = misalign_q;

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .offset (offset_q),
        .rdata  (data_rdata),
        .result (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            data_read     <= 1'b0;
            data_write    <= 1'b0;
            data_addr     <= 32'h0;
            data_mbe      <= 4'h0;
            data_wdata    <= 32'h0;
            load_data     <= 32'h0;
            mem_byte_en_o <= 4'h0;
            misalign_q    <= 1'b0;
            wait_cycles   <= '0;
            funct3_q      <= 3'h0;
            offset_q      <= 2'h0;
            lane_q        <= 4'h0;
            is_load_q     <= 1'b0;
            flushed_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (trap) begin
                            state         <= DONE;
                            misalign_q    <= 1'b1;
                            load_data     <= 32'h0;
                            mem_byte_en_o <= 4'h0;
                        end else begin
                            state       <= REQ;
                            data_read   <= mem_ctrl.mem_read;
                            data_write  <= mem_ctrl.mem_write && !mem_ctrl.mem_read;
                            data_addr   <= {mem_addr[31:2], 2'b00};
                            data_mbe    <= mem_ctrl.mem_read ? 4'b1111 : lane;
                            data_wdata  <= mem_ctrl.mem_read ? 32'h0 : (mem_rs2 << {offset_eff, 3'b000});
                            funct3_q    <= mem_ctrl.funct3;
                            offset_q    <= mem_addr[1:0];
                            lane_q      <= lane;
                            is_load_q   <= mem_ctrl.mem_read;
                            flushed_q   <= 1'b0;
                            wait_cycles <= '0;
                        end
                    end
                end
                REQ: begin
                    if (wait_cycles != '1)
                        wait_cycles <= wait_cycles + 1'b1;
                    if (flush)
                        flushed_q <= 1'b1;
                    if (data_resp) begin
                        state      <= DONE;
                        data_read  <= 1'b0;
                        data_write <= 1'b0;
                        // A flushed op still completes on the bus but retires nothing; stores return no data.
                        if (flushed_q || flush) begin
                            load_data     <= 32'h0;
                            mem_byte_en_o <= 4'h0;
                        end else begin
                            load_data     <= is_load_q ? ext_data : 32'h0;
                            mem_byte_en_o <= lane_q;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    misalign_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
